// File: rtl/csr_regfile_if.sv
// CSR access and exception-commit bus between the writeback stage and the CSR file.
// The master side is the pipeline; the slave side is csr_regfile.
interface csr_regfile_if;
  logic        csr_re;
  logic [13:0] csr_num;
  logic [31:0] csr_rvalue;
  logic        csr_we;
  logic [31:0] csr_wmask;
  logic [31:0] csr_wvalue;
  logic        wb_ex;
  logic [5:0]  wb_ecode;
  logic [8:0]  wb_esubcode;
  logic [31:0] wb_pc;
  logic [31:0] wb_vaddr;
  logic        ertn_flush;
  logic [7:0]  hw_int_in;
  logic        ipi_int_in;
  logic [31:0] ex_entry;
  logic [31:0] ertn_entry;
  logic        has_int;

  modport master (
    output csr_re, csr_num, csr_we, csr_wmask, csr_wvalue,
    output wb_ex, wb_ecode, wb_esubcode, wb_pc, wb_vaddr, ertn_flush,
    output hw_int_in, ipi_int_in,
    input  csr_rvalue, ex_entry, ertn_entry, has_int
  );

  modport slave (
    input  csr_re, csr_num, csr_we, csr_wmask, csr_wvalue,
    input  wb_ex, wb_ecode, wb_esubcode, wb_pc, wb_vaddr, ertn_flush,
    input  hw_int_in, ipi_int_in,
    output csr_rvalue, ex_entry, ertn_entry, has_int
  );
endinterface

// File: rtl/csr_regfile.sv
// Control/status register file: masked CSR writes, exception/ertn commit, interrupt
// latching and the stable timer.
module csr_regfile #(
  parameter int unsigned TIMER_W = 32,
  parameter logic [31:0] COREID  = 32'h0
) (
  input logic          clk,
  input logic          reset,
  csr_regfile_if.slave bus
);

  localparam logic [13:0] AddrCrmd   = 14'h000;
  localparam logic [13:0] AddrPrmd   = 14'h001;
  localparam logic [13:0] AddrEcfg   = 14'h004;
  localparam logic [13:0] AddrEstat  = 14'h005;
  localparam logic [13:0] AddrEra    = 14'h006;
  localparam logic [13:0] AddrBadv   = 14'h007;
  localparam logic [13:0] AddrEentry = 14'h00C;
  localparam logic [13:0] AddrSave0  = 14'h030;
  localparam logic [13:0] AddrSave1  = 14'h031;
  localparam logic [13:0] AddrSave2  = 14'h032;
  localparam logic [13:0] AddrSave3  = 14'h033;
  localparam logic [13:0] AddrTid    = 14'h040;
  localparam logic [13:0] AddrTcfg   = 14'h041;
  localparam logic [13:0] AddrTval   = 14'h042;
  localparam logic [13:0] AddrTiclr  = 14'h044;

  localparam logic [8:0] CrmdReset = 9'h008;

  logic [8:0]         crmd_q, crmd_d;
  logic [2:0]         prmd_q, prmd_d;
  logic [12:0]        lie_q, lie_d;
  logic [1:0]         is_sw_q, is_sw_d;
  logic [7:0]         is_hw_q, is_hw_d;
  logic               is_ti_q, is_ti_d;
  logic               is_ipi_q, is_ipi_d;
  logic [5:0]         ecode_q, ecode_d;
  logic [8:0]         esubcode_q, esubcode_d;
  logic [31:0]        era_q, era_d;
  logic [31:0]        badv_q, badv_d;
  logic [25:0]        eentry_q, eentry_d;
  logic [31:0]        save0_q, save0_d;
  logic [31:0]        save1_q, save1_d;
  logic [31:0]        save2_q, save2_d;
  logic [31:0]        save3_q, save3_d;
  logic [31:0]        tid_q, tid_d;
  logic [TIMER_W-1:0] tcfg_q, tcfg_d;
  logic [TIMER_W-1:0] tval_q, tval_d;

  logic [31:0] estat_rd;
  logic [31:0] csr_raw;
  logic [31:0] wdata;
  logic        wr_en;
  logic        timer_fire;
  logic        ticlr_clr;

  assign estat_rd = {1'b0, esubcode_q, ecode_q, 3'b000, is_ipi_q, is_ti_q, 1'b0,
                     is_hw_q, is_sw_q};

  always_comb begin
    csr_raw = '0;
    case (bus.csr_num)
      AddrCrmd:   csr_raw = {23'b0, crmd_q};
      AddrPrmd:   csr_raw = {29'b0, prmd_q};
      AddrEcfg:   csr_raw = {19'b0, lie_q};
      AddrEstat:  csr_raw = estat_rd;
      AddrEra:    csr_raw = era_q;
      AddrBadv:   csr_raw = badv_q;
      AddrEentry: csr_raw = {eentry_q, 6'b0};
      AddrSave0:  csr_raw = save0_q;
      AddrSave1:  csr_raw = save1_q;
      AddrSave2:  csr_raw = save2_q;
      AddrSave3:  csr_raw = save3_q;
      AddrTid:    csr_raw = tid_q;
      AddrTcfg:   csr_raw = 32'(tcfg_q);
      AddrTval:   csr_raw = 32'(tval_q);
      default:    csr_raw = '0;
    endcase
  end

  assign bus.csr_rvalue = bus.csr_re ? csr_raw : 32'h0;
  assign bus.ex_entry   = {eentry_q, 6'b0};
  assign bus.ertn_entry = era_q;
  assign bus.has_int    = crmd_q[2] & |(estat_rd[12:0] & lie_q);

  // Exception and ertn commits pre-empt any CSR write issued in the same cycle.
  assign wr_en      = bus.csr_we & ~bus.wb_ex & ~bus.ertn_flush;
  assign wdata      = (csr_raw & ~bus.csr_wmask) | (bus.csr_wvalue & bus.csr_wmask);
  assign timer_fire = tcfg_q[0] && (tval_q == TIMER_W'(1));

  always_comb begin
    crmd_d     = crmd_q;
    prmd_d     = prmd_q;
    lie_d      = lie_q;
    is_sw_d    = is_sw_q;
    is_hw_d    = bus.hw_int_in;
    is_ti_d    = is_ti_q;
    is_ipi_d   = bus.ipi_int_in;
    ecode_d    = ecode_q;
    esubcode_d = esubcode_q;
    era_d      = era_q;
    badv_d     = badv_q;
    eentry_d   = eentry_q;
    save0_d    = save0_q;
    save1_d    = save1_q;
    save2_d    = save2_q;
    save3_d    = save3_q;
    tid_d      = tid_q;
    tcfg_d     = tcfg_q;
    tval_d     = tval_q;
    ticlr_clr  = 1'b0;

    if (tcfg_q[0] && (tval_q != '0)) begin
      if (timer_fire) begin
        tval_d = tcfg_q[1] ? {tcfg_q[TIMER_W-1:2], 2'b00} : '0;
      end else begin
        tval_d = tval_q - TIMER_W'(1);
      end
    end

    if (wr_en) begin
      case (bus.csr_num)
        AddrCrmd:   crmd_d   = wdata[8:0];
        AddrPrmd:   prmd_d   = wdata[2:0];
        AddrEcfg:   lie_d    = wdata[12:0] & 13'h1BFF;
        AddrEstat:  is_sw_d  = wdata[1:0];
        AddrEra:    era_d    = wdata;
        AddrBadv:   badv_d   = wdata;
        AddrEentry: eentry_d = wdata[31:6];
        AddrSave0:  save0_d  = wdata;
        AddrSave1:  save1_d  = wdata;
        AddrSave2:  save2_d  = wdata;
        AddrSave3:  save3_d  = wdata;
        AddrTid:    tid_d    = wdata;
        AddrTcfg: begin
          tcfg_d = wdata[TIMER_W-1:0];
          // Enabled write reloads the counter; disabled write freezes it where it is.
          tval_d = tcfg_d[0] ? {tcfg_d[TIMER_W-1:2], 2'b00} : tval_q;
        end
        AddrTiclr:  ticlr_clr = wdata[0];
        default:    ;
      endcase
    end

    if (timer_fire) begin
      is_ti_d = 1'b1;
    end else if (ticlr_clr) begin
      is_ti_d = 1'b0;
    end

    if (bus.wb_ex) begin
      prmd_d     = crmd_q[2:0];
      crmd_d     = {crmd_q[8:3], 3'b000};
      era_d      = bus.wb_pc;
      ecode_d    = bus.wb_ecode;
      esubcode_d = bus.wb_esubcode;
      if (bus.wb_ecode == 6'h08) begin
        badv_d = bus.wb_pc;
      end else if (bus.wb_ecode == 6'h09) begin
        badv_d = bus.wb_vaddr;
      end
    end else if (bus.ertn_flush) begin
      crmd_d = {crmd_q[8:3], prmd_q};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      crmd_q     <= CrmdReset;
      prmd_q     <= '0;
      lie_q      <= '0;
      is_sw_q    <= '0;
      is_hw_q    <= '0;
      is_ti_q    <= 1'b0;
      is_ipi_q   <= 1'b0;
      ecode_q    <= '0;
      esubcode_q <= '0;
      era_q      <= '0;
      badv_q     <= '0;
      eentry_q   <= '0;
      save0_q    <= '0;
      save1_q    <= '0;
      save2_q    <= '0;
      save3_q    <= '0;
      tid_q      <= COREID;
      tcfg_q     <= '0;
      tval_q     <= '0;
    end else begin
      crmd_q     <= crmd_d;
      prmd_q     <= prmd_d;
      lie_q      <= lie_d;
      is_sw_q    <= is_sw_d;
      is_hw_q    <= is_hw_d;
      is_ti_q    <= is_ti_d;
      is_ipi_q   <= is_ipi_d;
      ecode_q    <= ecode_d;
      esubcode_q <= esubcode_d;
      era_q      <= era_d;
      badv_q     <= badv_d;
      eentry_q   <= eentry_d;
      save0_q    <= save0_d;
      save1_q    <= save1_d;
      save2_q    <= save2_d;
      save3_q    <= save3_d;
      tid_q      <= tid_d;
      tcfg_q     <= tcfg_d;
      tval_q     <= tval_d;
    end
  end

endmodule
